// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state codes and the conditional-negate helper for muldiv_unit.
// The decoder in the control unit imports the same op constants.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef logic [1:0] md_state_t;
    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_RUN  = 2'd1;
    localparam md_state_t ST_FIX  = 2'd2;

    // Widest value the helper handles; covers the 2*WIDTH product for WIDTH <= 64.
    localparam int MD_MAX_W = 128;

    // Two's-complement negate when neg=1. Truncating the result to N bits gives the
    // N-bit negation, so callers zero-extend in and cast back down.
    function automatic logic [MD_MAX_W-1:0] cond_neg(input logic [MD_MAX_W-1:0] v,
                                                     input logic neg);
        return neg ? (~v + MD_MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b,
                    input  busy, done, div_by_zero, hi, lo);
    modport slave  (input  start, op, a, b,
                    output busy, done, div_by_zero, hi, lo);

endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers; WIDTH+2 cycle issue interval.
// MTHI/MTLO write HI/LO in a single idle cycle.
import muldiv_pkg::*;

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int W2    = 2 * WIDTH;

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             dbz_cur;
    logic             dbz_flag;
    logic             done_r;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] rem;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             op_md;
    logic             op_div;
    logic             op_signed;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    assign op_md     = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                       (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign sa        = op_signed && bus.a[WIDTH-1];
    assign sb        = op_signed && bus.b[WIDTH-1];
    assign mag_a     = WIDTH'(cond_neg(MD_MAX_W'(bus.a), sa));
    assign mag_b     = WIDTH'(cond_neg(MD_MAX_W'(bus.b), sb));

    // Shift-add step: add multiplicand into the upper half when the current multiplier bit is set.
    assign mul_sum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Restoring-division step: quotient bits shift out of acc[WIDTH-1] into the remainder.
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});

    always_comb begin
        prod   = '0;
        fix_hi = '0;
        fix_lo = '0;
        if (is_div) begin
            if (dbz_cur) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_lo = WIDTH'(cond_neg(MD_MAX_W'(acc[WIDTH-1:0]), neg_res));
                fix_hi = WIDTH'(cond_neg(MD_MAX_W'(rem), neg_rem));
            end
        end else begin
            prod             = W2'(cond_neg(MD_MAX_W'(acc), neg_res));
            {fix_hi, fix_lo} = prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dbz_cur  <= 1'b0;
            dbz_flag <= 1'b0;
            done_r   <= 1'b0;
            opnd     <= '0;
            a_raw    <= '0;
            rem      <= '0;
            acc      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (op_md) begin
                            state    <= ST_RUN;
                            cnt      <= CNT_W'(WIDTH);
                            is_div   <= op_div;
                            neg_res  <= sa ^ sb;
                            neg_rem  <= sa;
                            dbz_cur  <= op_div && (bus.b == '0);
                            dbz_flag <= 1'b0;
                            a_raw    <= bus.a;
                            rem      <= '0;
                            if (op_div) begin
                                acc  <= {{WIDTH{1'b0}}, mag_a};
                                opnd <= mag_b;
                            end else begin
                                acc  <= {{WIDTH{1'b0}}, mag_b};
                                opnd <= mag_a;
                            end
                        end else if (bus.op == OP_MTHI) begin
                            hi_r <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_r <= bus.a;
                        end
                    end
                end
                ST_RUN: begin
                    if (is_div) begin
                        if (div_ge)
                            rem <= WIDTH'(div_shift - {1'b0, opnd});
                        else
                            rem <= div_shift[WIDTH-1:0];
                        acc <= {acc[W2-1:WIDTH], acc[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    hi_r     <= fix_hi;
                    lo_r     <= fix_lo;
                    done_r   <= 1'b1;
                    dbz_flag <= dbz_cur;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_flag;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: WIDTH=32 instance for the main flows, WIDTH=8 for the narrow rerun.
import muldiv_pkg::*;

module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst32;
    logic rst8;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) m32 ();
    muldiv_if #(.WIDTH(8))  m8 ();

    muldiv_unit #(.WIDTH(32)) u32 (.clk(clk), .rst(rst32), .bus(m32));
    muldiv_unit #(.WIDTH(8))  u8  (.clk(clk), .rst(rst8),  .bus(m8));

    // Drive one request on the 32-bit unit; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        m32.start = 1'b1;
        m32.op    = op;
        m32.a     = a;
        m32.b     = b;
        @(posedge clk);
        #1;
        m32.start = 1'b0;
        m32.a     = 32'hDEAD_BEEF;
        m32.b     = 32'hDEAD_BEEF;
    endtask

    // Counts edges until done (-1 on timeout) and cycles with busy=1 seen before it.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = -1;
        busy_cyc = m32.busy ? 1 : 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (m32.done) begin
                lat = n;
                break;
            end
            if (m32.busy) busy_cyc++;
        end
    endtask

    task automatic test_reset;
        m32.start = 1'b0; m32.op = OP_MULT; m32.a = '0; m32.b = '0;
        m8.start  = 1'b0; m8.op  = OP_MULT; m8.a  = '0; m8.b  = '0;
        rst32 = 1'b1;
        rst8  = 1'b1;
        @(negedge clk);
        m32.start = 1'b1; m32.op = OP_MTHI; m32.a = 32'h5555_0000;
        @(posedge clk);
        #1;
        m32.start = 1'b0;
        total++; if (m32.hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", m32.hi); end
        total++; if (m32.lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", m32.lo); end
        total++; if (m32.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", m32.busy); end
        total++; if (m32.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", m32.done); end
        total++; if (m32.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", m32.div_by_zero); end
        @(negedge clk);
        rst32 = 1'b0;
        rst8  = 1'b0;
    endtask

    task automatic test_multu_max;
        int lat, bc;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        total++; if (lat !== 33) begin bad++; $display("FAIL multu_latency: got %0d want 33", lat); end
        total++; if (bc !== 33) begin bad++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
        total++; if (m32.busy !== 1'b0) begin bad++; $display("FAIL multu_busy_at_done: got %b want 0", m32.busy); end
        total++; if (m32.hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", m32.hi); end
        total++; if (m32.lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", m32.lo); end
        @(posedge clk); #1;
        total++; if (m32.done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse: got %b want 0", m32.done); end
    endtask

    task automatic test_mult_signed;
        int lat, bc;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, bc);
        total++; if (m32.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", m32.hi); end
        total++; if (m32.lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo: got %h want ffffffeb", m32.lo); end
    endtask

    task automatic test_divide;
        int lat, bc;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bc);
        total++; if (m32.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", m32.lo); end
        total++; if (m32.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", m32.hi); end
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat, bc);
        total++; if (lat !== 33) begin bad++; $display("FAIL divu_latency: got %0d want 33", lat); end
        total++; if (m32.lo !== 32'd14) begin bad++; $display("FAIL divu_lo: got %0d want 14", m32.lo); end
        total++; if (m32.hi !== 32'd2) begin bad++; $display("FAIL divu_hi: got %0d want 2", m32.hi); end
        total++; if (m32.div_by_zero !== 1'b0) begin bad++; $display("FAIL divu_dbz: got %b want 0", m32.div_by_zero); end
    endtask

    task automatic test_div_edges;
        int lat, bc;
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        total++; if (m32.lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo: got %h want 80000000", m32.lo); end
        total++; if (m32.hi !== 32'h0) begin bad++; $display("FAIL div_ovf_hi: got %h want 0", m32.hi); end
        total++; if (m32.div_by_zero !== 1'b0) begin bad++; $display("FAIL div_ovf_dbz: got %b want 0", m32.div_by_zero); end
        issue(OP_DIVU, 32'd5, 32'd0);
        wait_done(lat, bc);
        total++; if (lat !== 33) begin bad++; $display("FAIL dbz_latency: got %0d want 33", lat); end
        total++; if (m32.lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dbz_lo: got %h want ffffffff", m32.lo); end
        total++; if (m32.hi !== 32'd5) begin bad++; $display("FAIL dbz_hi: got %h want 5", m32.hi); end
        total++; if (m32.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag: got %b want 1", m32.div_by_zero); end
        @(posedge clk); #1;
        total++; if (m32.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag_held: got %b want 1", m32.div_by_zero); end
        // Signed DIV by zero of a negative dividend: raw pattern in hi, no sign fixup.
        issue(OP_DIV, 32'hFFFF_FFF0, 32'd0);
        total++; if (m32.div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_clear_on_accept: got %b want 0", m32.div_by_zero); end
        wait_done(lat, bc);
        total++; if (m32.hi !== 32'hFFFF_FFF0) begin bad++; $display("FAIL sdbz_hi: got %h want fffffff0", m32.hi); end
        total++; if (m32.lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sdbz_lo: got %h want ffffffff", m32.lo); end
    endtask

    task automatic test_move_ops;
        int lat, bc;
        issue(OP_MTHI, 32'h0000_1234, 32'h0);
        total++; if (m32.hi !== 32'h0000_1234) begin bad++; $display("FAIL mthi_hi: got %h want 00001234", m32.hi); end
        total++; if (m32.busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", m32.busy); end
        @(posedge clk); #1;
        total++; if (m32.done !== 1'b0) begin bad++; $display("FAIL mthi_done: got %b want 0", m32.done); end
        issue(OP_MTLO, 32'h0000_AAAA, 32'h0);
        total++; if (m32.lo !== 32'h0000_AAAA) begin bad++; $display("FAIL mtlo_lo: got %h want 0000aaaa", m32.lo); end
        // Undefined op leaves everything alone.
        issue(3'b111, 32'h1111_1111, 32'h0);
        total++; if (m32.lo !== 32'h0000_AAAA || m32.hi !== 32'h0000_1234 || m32.busy !== 1'b0) begin
            bad++; $display("FAIL undef_op: got hi=%h lo=%h busy=%b want 00001234/0000aaaa/0", m32.hi, m32.lo, m32.busy);
        end
        // MTLO while running is dropped and the running op still finishes on time.
        issue(OP_MULTU, 32'd2, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        m32.start = 1'b1; m32.op = OP_MTLO; m32.a = 32'h0000_5555;
        @(posedge clk); #1;
        m32.start = 1'b0;
        total++; if (m32.lo !== 32'h0000_AAAA) begin bad++; $display("FAIL mtlo_in_run: got %h want 0000aaaa", m32.lo); end
        wait_done(lat, bc);
        total++; if (lat !== 28) begin bad++; $display("FAIL mtlo_in_run_latency: got %0d want 28", lat); end
        total++; if (m32.lo !== 32'd6 || m32.hi !== 32'd0) begin bad++; $display("FAIL mtlo_in_run_result: got hi=%h lo=%h want 0/6", m32.hi, m32.lo); end
    endtask

    task automatic test_ignore_start;
        int lat, bc;
        issue(OP_MULTU, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        @(negedge clk);
        m32.start = 1'b1; m32.op = OP_DIVU; m32.a = 32'd9; m32.b = 32'd4;
        @(posedge clk); #1;
        m32.start = 1'b0;
        wait_done(lat, bc);
        total++; if (lat !== 23) begin bad++; $display("FAIL ignore_latency: got %0d want 23", lat); end
        total++; if (m32.lo !== 32'd30 || m32.hi !== 32'd0) begin bad++; $display("FAIL ignore_result: got hi=%h lo=%h want 0/30", m32.hi, m32.lo); end
        repeat (3) @(posedge clk); #1;
        total++; if (m32.busy !== 1'b0) begin bad++; $display("FAIL ignore_no_second: got busy=%b want 0", m32.busy); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        issue(OP_MULTU, 32'd2, 32'd3);
        wait_done(lat, bc);
        total++; if (m32.lo !== 32'd6) begin bad++; $display("FAIL b2b_first_lo: got %0d want 6", m32.lo); end
        m32.start = 1'b1; m32.op = OP_DIVU; m32.a = 32'd9; m32.b = 32'd4;
        @(posedge clk); #1;
        m32.start = 1'b0;
        total++; if (m32.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%b want 1", m32.busy); end
        wait_done(lat, bc);
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33 (34 from done)", lat); end
        total++; if (m32.lo !== 32'd2 || m32.hi !== 32'd1) begin bad++; $display("FAIL b2b_result: got hi=%0d lo=%0d want 1/2", m32.hi, m32.lo); end
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        int seen_done;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst32 = 1'b1;
        @(posedge clk); #1;
        total++; if (m32.hi !== 32'h0 || m32.lo !== 32'h0) begin bad++; $display("FAIL rst_mid_hilo: got hi=%h lo=%h want 0/0", m32.hi, m32.lo); end
        total++; if (m32.busy !== 1'b0 || m32.done !== 1'b0 || m32.div_by_zero !== 1'b0) begin
            bad++; $display("FAIL rst_mid_ctl: got busy=%b done=%b dbz=%b want 0", m32.busy, m32.done, m32.div_by_zero);
        end
        @(negedge clk);
        rst32 = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (m32.done) seen_done++;
        end
        total++; if (seen_done !== 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", seen_done); end

        @(negedge clk);
        m8.start = 1'b1; m8.op = OP_MULT; m8.a = 8'h80; m8.b = 8'hFF;
        @(posedge clk); #1;
        m8.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (m8.done) begin lat = n; break; end
        end
        total++; if (lat !== 9) begin bad++; $display("FAIL w8_latency: got %0d want 9", lat); end
        total++; if (m8.hi !== 8'h00 || m8.lo !== 8'h80) begin bad++; $display("FAIL w8_mult: got hi=%h lo=%h want 00/80", m8.hi, m8.lo); end
    endtask

    initial begin
        test_reset;
        test_multu_max;
        test_mult_signed;
        test_divide;
        test_div_edges;
        test_move_ops;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS CPU datapath, parametrised in operand width. Executes MULT, MULTU, DIV, DIVU in a fixed WIDTH+2 cycle sequence and MTHI/MTLO in one cycle. It sits beside the combinational ALU in EX. The pipeline stalls on `busy` and reads `hi`/`lo` directly for MFHI/MFLO.

## Interface
- WIDTH, 32, operand width; even, ≥4. Derived localparam CNT_W = $clog2(WIDTH+1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only when idle.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse: HI/LO just written by a mul/div.
- div_by_zero  out  1  registered with the last div; valid while `done`=1, held until next accepted mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU: latch |a|, |b| (magnitudes for signed ops, raw for unsigned), sign flags, CNT ← WIDTH. Then → RUN.
- IDLE, `start`=1, op MTHI/MTLO: hi←a or lo←a at that edge. Stay IDLE; no `busy`, no `done`.
- IDLE, `start`=1, undefined op: no effect.
- RUN, multiply: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- RUN: CNT decrements each cycle; at CNT=1 → FIX.
- FIX, MULT: negate the 2·WIDTH product if operand signs differ.
- FIX, DIV: negate quotient if signs differ; remainder takes the dividend's sign.
- FIX, all mul/div: write {hi,lo} (mul: hi = upper half) or hi=remainder, lo=quotient. Assert `done` next cycle; → IDLE.
- Divide by zero (b=0, DIV or DIVU): full latency still runs. Result hi=a (original, unsigned pattern), lo=all ones, sign fixup bypassed, `div_by_zero`=1.
- Signed overflow (DIV of 2^(WIDTH-1) pattern by all ones): lo=0x80..0, hi=0. No flag.
- `start` while RUN/FIX: ignored entirely, including MTHI/MTLO. Caller stalls on `busy`.
- Operand inputs are don't-care after the accept edge.

## Timing
- Accept at edge E0. `busy`=1 after E0 through the FIX cycle.
- hi/lo update and `done`=1 after edge E(WIDTH+1); `busy`=0 in the same cycle.
- Latency: start to result visible = WIDTH+1 edges. Issue interval WIDTH+2.
- `start` asserted during the `done` cycle is accepted (back-to-back).
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state IDLE, CNT=0.
- `rst` mid-operation aborts: hi/lo take reset values, no `done`.
- `rst` has priority over `start` at the same edge.

## Structure
- Shared package `muldiv_pkg`: op encoding constants (OP_MULT…OP_MTLO) and the FSM state enum. The decoder in the control unit imports the same constants.
- Single module; no sub-module needed.
- Magnitude/negate logic stays inline as a function in the package.

## Test plan
- Multiply (WIDTH=32):
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; `done` exactly 33 edges after accept; `busy` high for 33 cycles.
  - MULT −3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Divide:
  - DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100/7 → lo=14, hi=2; `div_by_zero`=0.
- Divide edge cases:
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 5/0 → lo=0xFFFFFFFF, hi=5, `div_by_zero`=1.
- Handshake and move ops:
  - MTHI 0x1234 while idle → hi=0x1234 next cycle, `busy` stays 0.
  - MTLO during RUN → lo unchanged; the running op completes normally.
  - Second `start` during RUN → ignored.
- Back-to-back and reset:
  - MULTU 2×3 with a new DIVU 9/4 issued in the `done` cycle → lo=6, then lo=2/hi=1 after 34 more edges.
  - `rst` at cycle 10 of RUN → all outputs 0, no `done` pulse; WIDTH=8 rerun of MULT −128×−1 → hi=0x00, lo=0x80.
